// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the LSU, one transaction in flight.
// Latency: request sampled in IDLE -> mem_req next cycle; port ack the cycle after mem_ready (min 2).
// Backpressure: requesters hold req until ack; timeout aborts a hung bus with an error ack.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TC_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nxt;
    logic [3:0]    d_streak, d_streak_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic        if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
    logic [31:0] if_rdata_nxt, d_rdata_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]  mem_be_nxt;
    logic        if_elig, d_elig, force_i;

    always_comb begin
        // A port whose ack is high this cycle may still be holding req; it must not be re-granted.
        if_elig       = if_req & ~if_ack;
        d_elig        = d_req & ~d_ack;
        force_i       = if_elig & (d_streak == STREAK_MAX);
        state_nxt     = state;
        d_streak_nxt  = d_streak;
        tcnt_nxt      = tcnt;
        if_ack_nxt    = 1'b0;
        if_err_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_ack_nxt     = 1'b0;
        d_err_nxt     = 1'b0;
        d_rdata_nxt   = d_rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;

        unique case (state)
            IDLE: begin
                if (d_elig && !force_i) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    mem_be_nxt    = d_be;
                    state_nxt     = BUSY_D;
                    // force_i is low here, so the streak is below its limit when IF waits
                    if (if_elig)
                        d_streak_nxt = d_streak + 4'd1;
                end else if (if_elig) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = 32'd0;
                    mem_be_nxt    = 4'hF;
                    state_nxt     = BUSY_I;
                    d_streak_nxt  = 4'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    tcnt_nxt    = '0;
                    state_nxt   = IDLE;
                    if (state == BUSY_I) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_we ? 32'd0 : mem_rdata;
                    end
                end else if (tcnt == TC_LAST) begin
                    mem_req_nxt = 1'b0;
                    tcnt_nxt    = '0;
                    state_nxt   = IDLE;
                    if (state == BUSY_I) begin
                        if_ack_nxt   = 1'b1;
                        if_err_nxt   = 1'b1;
                        if_rdata_nxt = 32'd0;
                    end else begin
                        d_ack_nxt   = 1'b1;
                        d_err_nxt   = 1'b1;
                        d_rdata_nxt = 32'd0;
                    end
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            d_streak  <= 4'd0;
            tcnt      <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'd0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else begin
            state     <= state_nxt;
            d_streak  <= d_streak_nxt;
            tcnt      <= tcnt_nxt;
            if_ack    <= if_ack_nxt;
            if_err    <= if_err_nxt;
            if_rdata  <= if_rdata_nxt;
            d_ack     <= d_ack_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_be    <= mem_be_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic        clk, rst;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference model: tracks who owns the bus and how long it has waited.
    logic        e_if_ack, e_if_err, e_d_ack, e_d_err, e_mem_req, e_mem_we;
    logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic [3:0]  e_mem_be;
    int          owner;   // 0 none, 1 fetch, 2 lsu
    int          age;     // busy cycles seen so far, this one included
    int          streak;
    bit          started = 0;
    logic [31:0] model_log[$];

    always @(posedge clk) begin : model
        bit prev_iack, prev_dack, ei, ed, to;
        if (!rst) begin
            {e_if_ack, e_if_err, e_d_ack, e_d_err, e_mem_req, e_mem_we} = '0;
            {e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata} = '0;
            e_mem_be = '0;
            owner = 0; age = 0; streak = 0;
            started = 1;
        end else begin
            prev_iack = e_if_ack;
            prev_dack = e_d_ack;
            {e_if_ack, e_if_err, e_d_ack, e_d_err} = '0;
            if (owner != 0) begin
                age++;
                if (mem_ready || age == TMO) begin
                    to = !mem_ready;
                    if (owner == 1) begin
                        e_if_ack = 1; e_if_err = to;
                        e_if_rdata = to ? 32'd0 : mem_rdata;
                    end else begin
                        e_d_ack = 1; e_d_err = to;
                        e_d_rdata = (to || e_mem_we) ? 32'd0 : mem_rdata;
                    end
                    owner = 0; age = 0; e_mem_req = 0;
                end
            end else begin
                ei = if_req && !prev_iack;
                ed = d_req && !prev_dack;
                if (ei && (!ed || streak == MAXS)) begin
                    streak = 0; owner = 1; e_mem_req = 1;
                    e_mem_we = 0; e_mem_addr = if_addr; e_mem_wdata = 0; e_mem_be = 4'hF;
                    model_log.push_back(if_addr);
                end else if (ed) begin
                    if (ei) streak = (streak < MAXS) ? streak + 1 : MAXS;
                    owner = 2; e_mem_req = 1;
                    e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_be = d_be;
                    model_log.push_back(d_addr);
                end
            end
        end
    end

    logic [31:0] dut_log[$];
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("if_ack",    if_ack,    e_if_ack);
            chk("if_err",    if_err,    e_if_err);
            chk("if_rdata",  if_rdata,  e_if_rdata);
            chk("d_ack",     d_ack,     e_d_ack);
            chk("d_err",     d_err,     e_d_err);
            chk("d_rdata",   d_rdata,   e_d_rdata);
            chk("mem_req",   mem_req,   e_mem_req);
            chk("mem_we",    mem_we,    e_mem_we);
            chk("mem_addr",  mem_addr,  e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_be",    {28'd0, mem_be}, {28'd0, e_mem_be});
            if (mem_req && !prev_req) dut_log.push_back(mem_addr);
            prev_req <= mem_req;
        end
    end

    // Bus responder: mem_ready resp_lat cycles after mem_req is first seen; -1 never answers.
    int          resp_lat  = 0;
    logic [31:0] resp_data = 32'd0;
    bit          stray     = 0;

    initial begin : responder
        int wcnt;
        wcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (!mem_req) begin
                wcnt = 0;
                if (stray) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'hBAD0BAD0;
                    stray = 0;
                end
            end else if (resp_lat >= 0) begin
                if (wcnt == resp_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_data;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ack(input bit is_d, input int max, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(is_d ? d_ack : if_ack) && n < max);
        if (!(is_d ? d_ack : if_ack)) chk(is_d ? "d_ack_wait" : "if_ack_wait", 0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin : stim
        int n, d_cnt;
        bit if_done, gap;
        logic [31:0] exp_order [6];
        exp_order = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h300, 32'h410};

        rst = 1'b0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        step(2);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 0);
        rst = 1'b1;
        step(1);

        // Single fetch, bus answers 3 cycles after mem_req rises.
        resp_lat = 3; resp_data = 32'h00000013;
        if_addr = 32'h0; if_req = 1;
        step(1);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_be", {28'd0, mem_be}, 32'hF);
        chk("t1_mem_we", mem_we, 0);
        wait_ack(0, 20, n);
        chk("t1_latency", n, 4);
        chk("t1_if_rdata", if_rdata, 32'h00000013);
        chk("t1_if_err", if_err, 0);
        if_req = 0;
        step(2);

        // Simultaneous requests: LSU store first, fetch issued in the d_ack cycle.
        resp_lat = 1; resp_data = 32'h00000537;
        if_addr = 32'h200; if_req = 1;
        d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'h3; d_req = 1;
        step(1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_be", {28'd0, mem_be}, 32'h3);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_ack(1, 20, n);
        chk("t2_d_rdata", d_rdata, 0);
        chk("t2_if_not_yet", mem_req, 0);
        d_req = 0;
        step(1);
        chk("t2_if_mem_req", mem_req, 1);
        chk("t2_if_addr", mem_addr, 32'h200);
        wait_ack(0, 20, n);
        chk("t2_if_rdata", if_rdata, 32'h00000537);
        if_req = 0;
        step(2);

        // Starvation: LSU keeps requesting, fetch pending. if_req is lowered in each
        // d_ack cycle so the next selection sees both ports eligible together.
        dut_log.delete(); model_log.delete();
        resp_lat = 1; resp_data = 32'h12345678;
        if_addr = 32'h300; if_req = 1;
        d_we = 0; d_addr = 32'h400; d_be = 4'hF; d_wdata = 0; d_req = 1;
        d_cnt = 0; if_done = 0; gap = 0;
        for (int c = 0; c < 600 && !(d_cnt == 5 && if_done); c++) begin
            step(1);
            if (gap) begin
                if (!if_done) if_req = 1;
                gap = 0;
            end
            if (d_ack) begin
                d_cnt++;
                d_addr = d_addr + 32'd4;
                if (d_cnt == 5) d_req = 0;
                if (!if_done) begin
                    if_req = 0;
                    gap = 1;
                end
            end
            if (if_ack) begin
                if_done = 1;
                if_req = 0;
            end
        end
        chk("t3_done", {31'd0, (d_cnt == 5 && if_done)}, 1);
        chk("t3_dut_grants", dut_log.size(), 6);
        chk("t3_model_grants", model_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < dut_log.size())   chk("t3_dut_order", dut_log[i], exp_order[i]);
            if (i < model_log.size()) chk("t3_model_order", model_log[i], exp_order[i]);
        end
        step(2);

        // Hung bus: error ack after 64 busy cycles, then a normal access.
        resp_lat = -1;
        d_we = 0; d_addr = 32'h500; d_be = 4'hF; d_req = 1;
        step(1);
        chk("t4_mem_req", mem_req, 1);
        wait_ack(1, 200, n);
        chk("t4_busy_cycles", n, 64);
        chk("t4_d_err", d_err, 1);
        chk("t4_d_rdata", d_rdata, 0);
        chk("t4_mem_req_off", mem_req, 0);
        d_req = 0;
        step(1);
        resp_lat = 0; resp_data = 32'h5555AAAA;
        d_addr = 32'h504; d_req = 1;
        step(1);
        d_addr = 32'h999; d_req = 0;   // both ignored while busy; ack still expected
        wait_ack(1, 20, n);
        chk("t4_retry_err", d_err, 0);
        chk("t4_retry_rdata", d_rdata, 32'h5555AAAA);
        step(2);

        // Reset while an LSU store is in flight.
        resp_lat = -1;
        d_we = 1; d_addr = 32'h600; d_wdata = 32'h11223344; d_be = 4'hC; d_req = 1;
        step(1);
        chk("t5_busy", mem_req, 1);
        step(2);
        rst = 0;
        step(1);
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_d_ack", d_ack, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        rst = 1;
        step(1);
        chk("t5_regrant", mem_req, 1);
        chk("t5_regrant_addr", mem_addr, 32'h600);
        resp_lat = 2;
        wait_ack(1, 20, n);
        chk("t5_d_err", d_err, 0);
        chk("t5_d_rdata", d_rdata, 0);
        d_req = 0;
        step(1);

        // Stray mem_ready in idle, then a fetch held through its ack cycle.
        stray = 1;
        step(3);
        chk("t6_idle", mem_req, 0);
        resp_lat = 0; resp_data = 32'h00000093;
        if_addr = 32'h700; if_req = 1;
        step(1);
        chk("t6_mem_req", mem_req, 1);
        wait_ack(0, 20, n);
        chk("t6_if_rdata", if_rdata, 32'h00000093);
        step(1);
        chk("t6_no_dup", mem_req, 0);
        if_req = 0;
        step(2);
        chk("t6_still_idle", mem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
